// File: rtl/key_debounce_pulse_if.sv
// Button-side signal bundle for key_debounce_pulse.
// The stimulus/board side (master) drives the raw key. The debouncer (slave)
// returns the clean level, the one-cycle advance strobe and its FSM state.
// Handshake: there is none. btn_in is a free-running asynchronous level.
// pressed is a registered level. pulse is a registered strobe that is
// qualified only by being high for a clock cycle.
interface key_debounce_pulse_if;
    logic       btn_in;
    logic       pressed;
    logic       pulse;
    logic [1:0] dbg_state;

    modport master (output btn_in, input pressed, input pulse, input dbg_state);
    modport slave  (input btn_in, output pressed, output pulse, output dbg_state);
endinterface

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner.
// The raw key passes through a 2-flop synchronizer and is normalized to btn_s
// (1 = active). A 4-state FSM accepts a press or release only after
// DEBOUNCE_CYCLES consecutive equal samples. Each accepted press emits one
// registered pulse. Optional auto-repeat re-issues pulses while the key is held.
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_debounce_pulse_if.slave  bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);
    localparam logic             INACTIVE   = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [DB_W-1:0]  db_cnt, db_cnt_nx;
    logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
    logic             rep_first, rep_first_nx;
    logic             pressed_q, pressed_nx;
    logic             pulse_q, pulse_nx;
    logic             sync1, sync2;
    logic             btn_s;
    logic [DB_W-1:0]  db_inc;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_target;

    // Two-flop synchronizer. It resets to the idle key level, so a key held
    // through reset looks like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    assign btn_s      = BTN_ACTIVE_LOW ? ~sync2 : sync2;
    assign db_inc     = db_cnt + DB_ONE;
    assign rep_inc    = rep_cnt + REP_ONE;
    assign rep_target = rep_first ? REP_DELAY : REP_PERIOD;

    // State, counters and the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            db_cnt    <= db_cnt_nx;
            rep_cnt   <= rep_cnt_nx;
            rep_first <= rep_first_nx;
            pressed_q <= pressed_nx;
            pulse_q   <= pulse_nx;
        end
    end

    // Next-state logic. pulse_nx defaults low, so any pulse lasts one cycle
    // unless the repeat logic asks for it again.
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        rep_cnt_nx   = rep_cnt;
        rep_first_nx = rep_first;
        pressed_nx   = pressed_q;
        pulse_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    if (DB_TARGET == DB_ONE) begin
                        state_nx     = HELD;
                        pressed_nx   = 1'b1;
                        pulse_nx     = 1'b1;
                        db_cnt_nx    = '0;
                        rep_cnt_nx   = '0;
                        rep_first_nx = 1'b1;
                    end else begin
                        state_nx  = ARM_PRESS;
                        db_cnt_nx = DB_ONE;
                    end
                end
            end
            ARM_PRESS: begin
                if (!btn_s) begin
                    state_nx  = IDLE;
                    db_cnt_nx = '0;
                end else if (db_inc == DB_TARGET) begin
                    state_nx     = HELD;
                    pressed_nx   = 1'b1;
                    pulse_nx     = 1'b1;
                    db_cnt_nx    = '0;
                    rep_cnt_nx   = '0;
                    rep_first_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_inc;
                end
            end
            HELD: begin
                // A release sample takes priority over a due repeat pulse.
                if (!btn_s) begin
                    if (DB_TARGET == DB_ONE) begin
                        state_nx   = IDLE;
                        pressed_nx = 1'b0;
                        db_cnt_nx  = '0;
                    end else begin
                        state_nx  = ARM_RELEASE;
                        db_cnt_nx = DB_ONE;
                    end
                end else if (REPEAT_EN) begin
                    if (rep_inc == rep_target) begin
                        pulse_nx     = 1'b1;
                        rep_cnt_nx   = '0;
                        rep_first_nx = 1'b0;
                    end else begin
                        rep_cnt_nx = rep_inc;
                    end
                end
            end
            ARM_RELEASE: begin
                if (btn_s) begin
                    // The release bounced. Go back to holding, and the repeat
                    // timer restarts from the initial delay.
                    state_nx     = HELD;
                    db_cnt_nx    = '0;
                    rep_cnt_nx   = '0;
                    rep_first_nx = 1'b1;
                end else if (db_inc == DB_TARGET) begin
                    state_nx   = IDLE;
                    pressed_nx = 1'b0;
                    db_cnt_nx  = '0;
                end else begin
                    db_cnt_nx = db_inc;
                end
            end
            default: begin
                state_nx  = IDLE;
                db_cnt_nx = '0;
            end
        endcase
    end

    assign bus.pressed   = pressed_q;
    assign bus.pulse     = pulse_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse. It runs two instances on the same key: one
// without auto-repeat and one with it. A window/run-length model predicts
// pressed and pulse for both instances on every cycle. Directed tests add
// literal timing expectations.
module tb_key_debounce_pulse;

    localparam int D      = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;

    int checks = 0;
    int errors = 0;

    key_debounce_pulse_if bus0 ();
    key_debounce_pulse_if bus1 ();
    assign bus0.btn_in = btn;
    assign bus1.btn_in = btn;

    key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .REPEAT_EN(1'b0),
                         .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
                         .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Clock and reset.
    always #5 clk = ~clk;

    // Behavioural model.
    // btn_s at an edge is the raw key from two edges earlier, inverted.
    // The pressed level flips when the last D samples all disagree with it.
    // A flip to pressed emits one pulse.
    // hold_run counts consecutive active samples after acceptance, or after a
    // return from a bounced release. A repeat pulse is due when
    // hold_run = DELAY + k*PERIOD.
    logic d1, d2;
    bit   win[$];
    bit   prev_bs;
    int   hold_run;
    logic m_pressed, m_pulse0, m_pulse1;

    task automatic model_reset();
        d1 = 1'b1;
        d2 = 1'b1;
        win.delete();
        for (int i = 0; i < D; i++) win.push_back(1'b0);
        prev_bs   = 1'b0;
        hold_run  = 0;
        m_pressed = 1'b0;
        m_pulse0  = 1'b0;
        m_pulse1  = 1'b0;
    endtask

    task automatic model_step();
        bit   bs;
        int   ones;
        logic was;
        bs = (d2 == 1'b0);
        d2 = d1;
        d1 = btn;
        win.push_back(bs);
        void'(win.pop_front());
        ones = 0;
        foreach (win[i]) ones += int'(win[i]);
        was      = m_pressed;
        m_pulse0 = 1'b0;
        m_pulse1 = 1'b0;
        if (!was && ones == D) begin
            m_pressed = 1'b1;
            m_pulse0  = 1'b1;
            m_pulse1  = 1'b1;
        end else if (was && ones == 0) begin
            m_pressed = 1'b0;
        end
        if (was && m_pressed && bs && prev_bs) begin
            hold_run++;
            if (hold_run >= DELAY && ((hold_run - DELAY) % PERIOD) == 0) m_pulse1 = 1'b1;
        end else begin
            hold_run = 0;
        end
        prev_bs = bs;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Scoreboard check.
    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("pressed0", {1'b0, bus0.pressed}, {1'b0, m_pressed});
            check("pulse0",   {1'b0, bus0.pulse},   {1'b0, m_pulse0});
            check("pressed1", {1'b0, bus1.pressed}, {1'b0, m_pressed});
            check("pulse1",   {1'b0, bus1.pulse},   {1'b0, m_pulse1});
        end
    end

    // Driver helpers.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, output int p0, output int p1);
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            p0 += int'(bus0.pulse);
            p1 += int'(bus1.pulse);
        end
    endtask

    int c0, c1;
    int pulse_at[$];
    int exp_at[6] = '{6, 26, 34, 42, 50, 58};

    initial begin
        // 1: reset with the key held, then a fresh press after full debounce.
        btn = 1'b0;
        #1;
        check("rst_pressed", {1'b0, bus0.pressed}, 2'd0);
        check("rst_pulse",   {1'b0, bus0.pulse},   2'd0);
        check("rst_state",   bus0.dbg_state,       2'd0);
        repeat (3) tick();
        rst = 1'b1;
        ticks(5, c0, c1);
        check("rst_no_early_pulse", {1'b0, bus0.pulse}, 2'd0);
        check("rst_early_count", c0[1:0], 2'd0);
        tick();
        check("rst_pulse_e5", {1'b0, bus0.pulse}, 2'd1);
        tick();
        check("rst_pulse_e6", {1'b0, bus0.pulse}, 2'd0);
        btn = 1'b1;
        ticks(12, c0, c1);

        // 2: clean press held 40 cycles, then release.
        btn = 1'b0;
        ticks(5, c0, c1);
        check("press_pressed_e4", {1'b0, bus0.pressed}, 2'd0);
        tick();
        check("press_pressed_e5", {1'b0, bus0.pressed}, 2'd1);
        check("press_pulse_e5",   {1'b0, bus0.pulse},   2'd1);
        tick();
        check("press_pulse_e6",   {1'b0, bus0.pulse},   2'd0);
        ticks(33, c0, c1);
        check("press_no_more_pulses", c0[1:0], 2'd0);
        btn = 1'b1;
        ticks(5, c0, c1);
        check("rel_pressed_e4", {1'b0, bus0.pressed}, 2'd1);
        tick();
        check("rel_pressed_e5", {1'b0, bus0.pressed}, 2'd0);
        ticks(6, c0, c1);
        check("rel_no_pulse", c0[1:0], 2'd0);

        // 3: bounce of low 3 / high 1, repeated 5 times, then a stable low.
        c0 = 0;
        for (int k = 0; k < 5; k++) begin
            int a, b;
            btn = 1'b0;
            ticks(3, a, b);
            btn = 1'b1;
            ticks(1, b, c1);
            c0 += a + b;
        end
        btn = 1'b0;
        ticks(5, c1, c1);
        check("bounce_no_pulse", c0[1:0], 2'd0);
        check("bounce_no_pulse_tail", {1'b0, bus0.pulse}, 2'd0);
        tick();
        check("bounce_pulse_e5", {1'b0, bus0.pulse}, 2'd1);

        // 4: release bounce while held. pressed stays high and returns to HELD.
        ticks(10, c0, c1);
        btn = 1'b1;
        ticks(2, c0, c1);
        btn = 1'b0;
        ticks(10, c1, c1);
        check("relbounce_pulses", c0[1:0], 2'd0);
        check("relbounce_pressed", {1'b0, bus0.pressed}, 2'd1);
        check("relbounce_state", bus0.dbg_state, 2'd2);
        btn = 1'b1;
        ticks(12, c0, c1);

        // 5: auto-repeat on dut1. Hold 60 cycles, then release mid-period.
        btn = 1'b0;
        pulse_at.delete();
        for (int i = 1; i <= 80; i++) begin
            if (i == 61) btn = 1'b1;
            tick();
            if (bus1.pulse) pulse_at.push_back(i);
        end
        check("repeat_count", 2'(pulse_at.size() == 6), 2'd1);
        for (int i = 0; i < 6; i++) begin
            int got;
            got = (i < pulse_at.size()) ? pulse_at[i] : -1;
            checks++;
            if (got != exp_at[i]) begin
                errors++;
                $display("FAIL repeat_tick[%0d]: got %0d expected %0d", i, got, exp_at[i]);
            end
        end

        // 6: asynchronous reset in the middle of ARM_PRESS.
        btn = 1'b0;
        ticks(4, c0, c1);
        check("abort_state_arm", bus0.dbg_state, 2'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_state",   bus0.dbg_state,       2'd0);
        check("abort_pressed", {1'b0, bus0.pressed}, 2'd0);
        check("abort_pulse",   {1'b0, bus0.pulse},   2'd0);
        btn = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        ticks(12, c0, c1);
        check("abort_no_pulse", c0[1:0], 2'd0);

        // Random key activity with a mix of short glitches and long holds.
        for (int r = 0; r < 400; r++) begin
            int len;
            btn = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 7);
            if (r == 200) begin
                rst = 1'b0;
                repeat (2) tick();
                rst = 1'b1;
            end
            ticks(len, c0, c1);
        end
        btn = 1'b1;
        ticks(12, c0, c1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
